// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the memory / write-back stage.
// Holds the SRAM access FSM states and SRAM geometry.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        DONE
    } mem_state_e;

    localparam int MEM_BASE_DEF = 1024;
    localparam int SRAM_AW_DEF  = 18;
    localparam int SRAM_DW      = 16;
    localparam int WAIT_DEF     = 2;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM access sequencer: splits a 32-bit load/store into two
// 16-bit halfword accesses, each held for WAIT_CYCLES cycles.
module sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_DEF,
    parameter int MEM_BASE    = MEM_BASE_DEF,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               is_load,
    input  logic [31:0]        addr_in,
    input  logic [31:0]        wdata,
    input  logic [15:0]        sram_dq_in,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic [31:0]        rdata,
    output logic               done
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    mem_state_e         state;
    mem_state_e         state_n;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               in_acc;
    logic [SRAM_AW-2:0] w;
    logic [31:0]        rbuf;

    assign w      = (SRAM_AW-1)'((addr_in - 32'(MEM_BASE)) >> 2);
    assign last   = (cnt == LAST);
    assign in_acc = (state == ACC_LO) || (state == ACC_HI);
    assign rdata  = rbuf;
    assign done   = (state == DONE);

    // State, hold counter and read buffer; loads sample on the last hold cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rbuf  <= '0;
        end else begin
            state <= state_n;
            if (in_acc && !last)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if (is_load && last && state == ACC_LO)
                rbuf[15:0] <= sram_dq_in;
            if (is_load && last && state == ACC_HI)
                rbuf[31:16] <= sram_dq_in;
        end
    end

    // Next state and SRAM pin drive; stores strobe for every hold cycle.
    always_comb begin
        state_n     = state;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state)
            IDLE: begin
                if (req)
                    state_n = ACC_LO;
            end
            ACC_LO: begin
                sram_addr = {w, 1'b0};
                if (!is_load) begin
                    sram_dq_out = wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (last)
                    state_n = ACC_HI;
            end
            ACC_HI: begin
                sram_addr = {w, 1'b1};
                if (!is_load) begin
                    sram_dq_out = wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (last)
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory + write-back stage: holds the pipeline during SRAM
// accesses and registers the triple for the register file.
module mem_wb_stage
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_DEF,
    parameter int MEM_BASE    = MEM_BASE_DEF,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        val_rm,
    input  logic [3:0]         dest_in,
    output logic               freeze,
    output logic               writeBackEn,
    output logic [3:0]         Dest_wb,
    output logic [31:0]        Result_wb,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    logic        req;
    logic        done;
    logic [31:0] rdata;

    assign req    = mem_r_en | mem_w_en;
    assign freeze = req & ~done;

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .MEM_BASE    (MEM_BASE),
        .SRAM_AW     (SRAM_AW)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .is_load     (mem_r_en),
        .addr_in     (alu_result),
        .wdata       (val_rm),
        .sram_dq_in  (sram_dq_in),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .rdata       (rdata),
        .done        (done)
    );

    // Write-back registers; a frozen cycle retires a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_wb   <= '0;
        end else if (freeze) begin
            writeBackEn <= 1'b0;
        end else begin
            writeBackEn <= wb_en_in;
            Dest_wb     <= dest_in;
            Result_wb   <= mem_r_en ? rdata : alu_result;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a small SRAM model.
// Expected values are hand-computed constants.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        wb_en_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic [3:0]  dest_in;
    logic        freeze;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic [15:0] mem [64];
    int          nwr;
    int          n_assert;
    int          n_fail;
    int          nf;
    int          w0;
    logic [17:0] a_lo;
    logic [17:0] a_hi;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en_in    (wb_en_in),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .alu_result  (alu_result),
        .val_rm      (val_rm),
        .dest_in     (dest_in),
        .freeze      (freeze),
        .writeBackEn (writeBackEn),
        .Dest_wb     (Dest_wb),
        .Result_wb   (Result_wb),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[5:0]];

    // SRAM model: preload words 2/3 in reset, write on strobe.
    always @(posedge clk) begin
        if (rst) begin
            mem[2] <= 16'h5678;
            mem[3] <= 16'h9ABC;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq_out;
            nwr <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait out a memory op; ends just after the DONE-cycle posedge.
    task automatic run_mem();
        #1;
        nf   = 0;
        a_lo = '1;
        a_hi = '1;
        while (freeze && nf < 20) begin
            if (nf == 1) a_lo = sram_addr;
            if (nf == 3) a_hi = sram_addr;
            nf++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic we, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] d);
        wb_en_in   = we;
        mem_r_en   = r;
        mem_w_en   = w;
        alu_result = a;
        val_rm     = v;
        dest_in    = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nwr      = 0;
        rst      = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_wben", 32'(writeBackEn), 0);
        chk("rst_dest", 32'(Dest_wb), 0);
        chk("rst_res", Result_wb, 0);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_oe", 32'(sram_dq_oe), 0);
        chk("rst_addr", 32'(sram_addr), 0);

        // ALU op
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 32'h55, 0, 3);
        #1;
        chk("alu_freeze", 32'(freeze), 0);
        @(posedge clk);
        #1;
        chk("alu_wben", 32'(writeBackEn), 1);
        chk("alu_dest", 32'(Dest_wb), 3);
        chk("alu_res", Result_wb, 32'h55);

        // STR 0x1234ABCD @1024
        @(negedge clk);
        drive(0, 0, 1, 1024, 32'h1234ABCD, 4);
        w0 = nwr;
        run_mem();
        chk("str_nfreeze", nf, 5);
        chk("str_bubble", 32'(writeBackEn), 0);
        chk("str_alo", 32'(a_lo), 0);
        chk("str_ahi", 32'(a_hi), 1);
        @(posedge clk);
        #1;
        chk("str_wben", 32'(writeBackEn), 0);
        chk("str_nwr", nwr - w0, 4);
        chk("str_m0", 32'(mem[0]), 32'hABCD);
        chk("str_m1", 32'(mem[1]), 32'h1234);

        // LDR @1024 dest 7
        @(negedge clk);
        drive(1, 1, 0, 1024, 0, 7);
        run_mem();
        chk("ld0_nfreeze", nf, 5);
        chk("ld0_bubble", 32'(writeBackEn), 0);
        @(posedge clk);
        #1;
        chk("ld0_wben", 32'(writeBackEn), 1);
        chk("ld0_dest", 32'(Dest_wb), 7);
        chk("ld0_res", Result_wb, 32'h1234ABCD);

        // LDR @1028 dest 9, back-to-back
        @(negedge clk);
        drive(1, 1, 0, 1028, 0, 9);
        run_mem();
        chk("ld1_nfreeze", nf, 5);
        chk("ld1_alo", 32'(a_lo), 2);
        chk("ld1_ahi", 32'(a_hi), 3);
        @(posedge clk);
        #1;
        chk("ld1_wben", 32'(writeBackEn), 1);
        chk("ld1_dest", 32'(Dest_wb), 9);
        chk("ld1_res", Result_wb, 32'h9ABC5678);

        // Load and store both set: load wins
        @(negedge clk);
        drive(1, 1, 1, 1024, 32'hDEADBEEF, 5);
        w0 = nwr;
        run_mem();
        chk("both_nfreeze", nf, 5);
        @(posedge clk);
        #1;
        chk("both_nwr", nwr - w0, 0);
        chk("both_wben", 32'(writeBackEn), 1);
        chk("both_res", Result_wb, 32'h1234ABCD);
        chk("both_m0", 32'(mem[0]), 32'hABCD);

        // Async reset mid-store
        @(negedge clk);
        drive(1, 0, 1, 1032, 32'hCAFEF00D, 2);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_we_n", 32'(sram_we_n), 0);
        rst = 1'b1;
        #1;
        chk("mrst_we_n", 32'(sram_we_n), 1);
        chk("mrst_oe", 32'(sram_dq_oe), 0);
        chk("mrst_addr", 32'(sram_addr), 0);
        chk("mrst_wben", 32'(writeBackEn), 0);
        chk("mrst_dest", 32'(Dest_wb), 0);
        chk("mrst_res", Result_wb, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_wben", 32'(writeBackEn), 0);
        chk("post_rst_freeze", 32'(freeze), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
